multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle main control FSM for the CPU datapath (IR, immediate generator, ALU, regfile, PC, unified memory).
//  Sequences FETCH/DECODE/EXEC/MEM/WB per instruction and drives every datapath strobe and mux select.
//  Supports R-type (0110011), I-ALU (0010011), LW (0000011), SW (0100011) and BEQ/BNE (1100011).
//  Memory access is a valid/ready handshake with a bus-timeout watchdog. Illegal encodings trap.
// PARAMETERS
//  TIMEOUT_CYCLES  255  consecutive mem_req cycles without mem_ready before a bus trap; 0 = watchdog off
//  CNT_W           32   width of the retired-instruction counter
// PORTS
//  clk         in   1      clock; all flops on the rising edge
//  rst_n       in   1      asynchronous active-low reset
//  opcode      in   7      IR[6:0]; stable from DECODE until the instruction retires
//  funct3      in   3      IR[14:12]
//  alu_zero    in   1      ALU result == 0
//  mem_ready   in   1      memory accepted write / returned read data this cycle
//  mem_req     out  1      memory request valid
//  mem_we      out  1      1 = write (SW), 0 = read
//  iord        out  1      memory address select: 0 = PC, 1 = ALU result
//  ir_we       out  1      load IR from memory read data
//  pc_we       out  1      update PC
//  pc_src      out  1      0 = PC+4, 1 = PC + immediate (branch target)
//  reg_we      out  1      regfile write enable
//  wb_sel      out  1      regfile write data: 0 = ALU result, 1 = memory read data
//  alu_src_b   out  1      ALU operand B: 0 = rs2, 1 = immediate
//  alu_op      out  2      00 = add, 01 = subtract (compare), 10 = decode from funct3/funct7
//  state       out  3      current state encoding, for debug
//  retired     out  CNT_W  retired-instruction count
//  trap        out  1      sticky trap flag
//  trap_cause  out  2      00 = none, 01 = illegal instruction, 10 = bus timeout
// BEHAVIOUR
//  State encoding: IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 TRAP=7.
//  Reset: asynchronous, to IDLE. Outputs go to 0 immediately, without waiting for a clock edge: all strobes,
//   trap, trap_cause, retired, watchdog count.
//  IDLE: all outputs 0; goes to FETCH on the next cycle unconditionally.
//  FETCH: mem_req=1, iord=0, mem_we=0. On mem_ready: ir_we=1 that cycle (Mealy), then DECODE.
//   Otherwise stay in FETCH.
//  DECODE: legal opcode goes to EXEC. Opcode 1100011 with funct3 other than 000 or 001 is illegal.
//   Any unsupported opcode is illegal: go to TRAP with cause 01.
//  EXEC, R-type: alu_src_b=0, alu_op=10, then WB.
//  EXEC, I-ALU: alu_src_b=1, alu_op=10, then WB.
//  EXEC, LW/SW: alu_src_b=1, alu_op=00, then MEM.
//  EXEC, branch: alu_src_b=0, alu_op=01; pc_we=1, pc_src = alu_zero XOR funct3[0]; retire; then FETCH.
//  MEM: mem_req=1, iord=1, mem_we=(SW). Wait for mem_ready.
//   SW on mem_ready: pc_we=1, pc_src=0, retire, then FETCH. LW on mem_ready: go to WB.
//  WB: reg_we=1, wb_sel=(LW), pc_we=1, pc_src=0, retire, then FETCH.
//  All outputs are Moore, except ir_we and the MEM-completion pc_we, which are qualified by mem_ready.
//  Handshake rules:
//   - Once asserted, mem_req, mem_we and iord are held constant until the mem_ready cycle.
//   - mem_ready while mem_req=0 is ignored.
//   - mem_ready in the first request cycle completes that cycle (zero wait).
//  Latency with zero wait states: branch 3, R/I/SW 4, LW 5 cycles. Each wait cycle adds 1.
//  Retire: retired increments by 1 in the completion cycle; wraps modulo 2^CNT_W.
//  Watchdog: counts cycles with mem_req=1 and mem_ready=0; cleared when mem_ready=1 or state changes.
//   When the count reaches TIMEOUT_CYCLES: go to TRAP with cause 10.
//   A mem_ready arriving in that same cycle wins (completes normally, no trap).
//  TRAP: sticky. All strobes 0, trap=1, trap_cause held; retired is not incremented. Leave only via rst_n.
//  Reset mid-instruction: mem_req and mem_we drop asynchronously; the instruction is not retired.
// TESTING
//  1. ADDI 0x00500093, mem_ready=1 always -> state 0,1,2,3,5,1. ir_we one cycle in FETCH.
//     reg_we and pc_we (pc_src=0) one cycle in WB. retired goes 0->1.
//  2. LW with mem_ready low 3 cycles in MEM -> mem_req, iord=1, mem_we=0 held 4 cycles.
//     Then WB with wb_sel=1; 8 cycles FETCH-to-FETCH.
//  3. BEQ with alu_zero=1 -> pc_we=1, pc_src=1 in EXEC. BNE with alu_zero=1 -> pc_src=0.
//     Both back in FETCH after 3 cycles, no reg_we.
//  4. Opcode 7'h7F, or 1100011 with funct3=3'b010 -> TRAP after DECODE, trap_cause=01.
//     No pc_we/reg_we; stays trapped 20 cycles, retired unchanged.
//  5. TIMEOUT_CYCLES=8, mem_ready=0 in FETCH -> TRAP with cause 10 exactly 8 mem_req cycles in.
//     Repeat with mem_ready=1 on the 8th cycle -> normal DECODE.
//  6. rst_n low mid-MEM of SW -> mem_req and mem_we drop before the next clk edge, retired=0.
//     After release: one IDLE cycle, then FETCH.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle main control FSM sequencing fetch/decode/exec/mem/wb with bus watchdog and traps
module multicycle_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic             reg_we,
  output logic             wb_sel,
  output logic             alu_src_b,
  output logic [1:0]       alu_op,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             trap,
  output logic [1:0]       trap_cause
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd7;
  localparam int WD_W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

  logic [2:0] nxt;
  logic [WD_W-1:0] wd_cnt;
  logic is_r, is_i, is_lw, is_sw, is_br, legal, waiting, timeout, retire;

  assign is_r    = opcode == 7'b0110011;
  assign is_i    = opcode == 7'b0010011;
  assign is_lw   = opcode == 7'b0000011;
  assign is_sw   = opcode == 7'b0100011;
  assign is_br   = opcode == 7'b1100011;
  assign legal   = is_r | is_i | is_lw | is_sw | (is_br & (funct3[2:1] == 2'b00));
  assign waiting = mem_req & ~mem_ready;
  assign timeout = (TIMEOUT_CYCLES != 0) && waiting && (wd_cnt == WD_LAST);
  assign retire  = (state == S_EXEC && is_br) || (state == S_MEM && mem_ready && is_sw) || state == S_WB;

  assign mem_req    = state == S_FETCH || state == S_MEM;
  assign mem_we     = state == S_MEM && is_sw;
  assign iord       = state == S_MEM;
  assign ir_we      = state == S_FETCH && mem_ready;
  assign pc_we      = retire;
  assign pc_src     = state == S_EXEC && is_br && (alu_zero ^ funct3[0]);
  assign reg_we     = state == S_WB;
  assign wb_sel     = state == S_WB && is_lw;
  assign alu_src_b  = state == S_EXEC && (is_i | is_lw | is_sw);
  assign alu_op     = state != S_EXEC ? 2'b00 : (is_r | is_i) ? 2'b10 : is_br ? 2'b01 : 2'b00;
  assign trap       = state == S_TRAP;

  // next-state selection; a mem_ready in the timeout cycle takes priority over the trap
  always_comb begin
    nxt = S_IDLE;
    case (state)
      S_IDLE:   nxt = S_FETCH;
      S_FETCH:  nxt = mem_ready ? S_DECODE : timeout ? S_TRAP : S_FETCH;
      S_DECODE: nxt = legal ? S_EXEC : S_TRAP;
      S_EXEC:   nxt = is_br ? S_FETCH : (is_lw | is_sw) ? S_MEM : S_WB;
      S_MEM:    nxt = mem_ready ? (is_sw ? S_FETCH : S_WB) : timeout ? S_TRAP : S_MEM;
      S_WB:     nxt = S_FETCH;
      S_TRAP:   nxt = S_TRAP;
      default:  nxt = S_IDLE;
    endcase
  end

  // state, trap cause, retire counter and bus watchdog
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      trap_cause <= 2'b00;
      retired    <= '0;
      wd_cnt     <= '0;
    end else begin
      state <= nxt;
      if (state != S_TRAP && nxt == S_TRAP) trap_cause <= state == S_DECODE ? 2'b01 : 2'b10;
      if (retire) retired <= retired + CNT_W'(1);
      wd_cnt <= (waiting && nxt == state) ? wd_cnt + 1'b1 : '0;
    end
  end
endmodule
